guess_entry: RTL and testbench
==============================

Name: guess_entry

Overview:
- Upstream input stage for the guess comparator; feeds its key0/key1/key2 and confirmButton inputs.
- Collects decimal digits from the keypad decoder into a right-aligned guess register of up to max_digit digits, with clear and backspace.
- Debounces the raw confirm push-button and emits a single-cycle confirm pulse only when a complete guess is present.
- Clears the guess automatically after each commit.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a button level change (min 1).
- CNT_W, 5, width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock
- restart  in  1  reset; one clock; reset is asynchronous and active-low
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle
- key_code  in  4  0-9 digit, 4'hA clear, 4'hB backspace, 4'hC-4'hF ignored
- confirm_n  in  1  raw confirm button, active-low, asynchronous to clk
- max_digit  in  2  digits required for a guess (1-3); 0 = entry disabled
- key0  out  4  least significant guess digit
- key1  out  4  middle guess digit
- key2  out  4  most significant guess digit
- digit_count  out  2  digits currently entered
- entry_ready  out  1  high when digit_count == max_digit and max_digit != 0
- confirm_pulse  out  1  one-cycle commit strobe to the comparator
- reject_pulse  out  1  one-cycle strobe when confirm is pressed on an incomplete guess

Behaviour:
- Reset (async assert, sync release):
  - key0/1/2 = 0, digit_count = 0, all pulses = 0, entry_ready = 0.
  - Sync flops and debounced level = released (1); debounce counter = 0; FSM = IDLE.
- FSM states:
  - IDLE: count = 0.
  - ENTRY: 0 < count < max_digit.
  - READY: count == max_digit.
  - COMMIT: single cycle, confirm_pulse = 1.
- Digit key (0-9) with count < max_digit:
  - key2 <= key1, key1 <= key0, key0 <= code, count + 1.
  - Visible the cycle after the strobe.
- Digit key in READY: ignored; no shift, no count change.
- Clear (A): keys = 0, count = 0, go to IDLE. Accepted in any state except COMMIT.
- Backspace (B) with count > 0: key0 <= key1, key1 <= key2, key2 <= 0, count - 1. Backspace in IDLE has no effect.
- Codes C-F: no effect.
- Confirm button path:
  - confirm_n passes through a 2-flop synchronizer.
  - The debounce counter increments while the synchronized value differs from the debounced level, and resets to 0 when it matches.
  - On reaching DEBOUNCE_CYCLES, the debounced level takes the synchronized value and the counter resets.
- Press event: debounced level goes 1 -> 0. Only one event per press; release generates nothing.
- Press event in READY: next cycle is COMMIT.
  - confirm_pulse = 1 for exactly one cycle; key0/1/2 and count hold during that cycle.
  - Following cycle: keys = 0, count = 0, state = IDLE.
- Press event in IDLE or ENTRY: reject_pulse = 1 for one cycle; guess unchanged.
- key_valid during COMMIT: ignored. The keypad source must not rely on it being held.
- Press event coinciding with key_valid in READY: the key is processed per the READY rules (digit ignored, clear or backspace applied). Confirm takes effect only if the state is still READY after that key.
- max_digit == 0: all keys ignored, no confirm or reject pulses, entry_ready = 0.
- max_digit changes while count > new max_digit: keys and count clear next cycle. Otherwise the entry is kept, and entry_ready and state re-evaluate.
- Reset asserted mid-commit: confirm_pulse drops immediately; all state returns to reset values.
- Press latency: confirm_pulse rises exactly 2 + DEBOUNCE_CYCLES + 1 clock edges after the first edge sampling confirm_n = 0 with a stable press.

Test Plan:
- DEBOUNCE_CYCLES = 4, max_digit = 3, keys 4, 7, 2 -> key2/1/0 = 4/7/2, count = 3, entry_ready = 1; extra key 9 -> unchanged.
- From the 4/7/2 guess, hold confirm_n = 0 -> confirm_pulse high exactly 7 edges after the press with keys still 4/7/2; next cycle keys = 0, count = 0, IDLE; a single press gives a single pulse.
- Bounce: confirm_n toggles every 2 cycles for 20 cycles, then releases -> no confirm_pulse and no reject_pulse.
- max_digit = 2, keys 5, B, 8, 3 -> key1/key0 = 8/3, count = 2; key A -> all zero, count 0; press -> reject_pulse once, no confirm_pulse.
- max_digit = 3 with digits 1, 2, 3 entered; change max_digit to 1 -> keys and count clear next cycle. Then max_digit = 0, key 6 and a press -> no change, no pulses.
- Assert restart during the COMMIT cycle -> confirm_pulse falls asynchronously; after release all outputs are zero and the debounced level is released.

Source files
------------

// File: rtl/guess_entry.sv
// guess_entry: keypad digit collection with clear/backspace and a debounced confirm button
// that commits a complete guess to the comparator.
module guess_entry #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       restart,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       confirm_n,
    input  logic [1:0] max_digit,
    output logic [3:0] key0,
    output logic [3:0] key1,
    output logic [3:0] key2,
    output logic [1:0] digit_count,
    output logic       entry_ready,
    output logic       confirm_pulse,
    output logic       reject_pulse
);
    typedef enum logic [1:0] {IDLE, ENTRY, READY, COMMIT} state_t;
    state_t state;
    logic sync1, sync2, level, level_q;
    logic [CNT_W-1:0] cnt;
    logic enabled, accept, press, do_shift, do_clear, do_back, commit, reject;
    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_q <= 1'b1;
            cnt     <= '0;
        end else begin
            sync1   <= confirm_n;
            sync2   <= sync1;
            level_q <= level;
            if (sync2 == level) cnt <= '0;
            else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
    // A press is the debounced level falling; release produces nothing.
    assign press       = level_q & ~level;
    assign enabled     = max_digit != 2'd0;
    assign entry_ready = enabled && digit_count == max_digit;
    assign accept      = key_valid && enabled && state != COMMIT;
    assign do_shift    = accept && key_code <= 4'd9 && digit_count < max_digit;
    assign do_clear    = accept && key_code == 4'hA;
    assign do_back     = accept && key_code == 4'hB && digit_count != 2'd0;
    assign commit      = press && entry_ready && state != COMMIT && !do_clear && !do_back;
    assign reject      = press && enabled && state != COMMIT && !commit;
    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            state         <= IDLE;
            key0          <= '0;
            key1          <= '0;
            key2          <= '0;
            digit_count   <= '0;
            confirm_pulse <= 1'b0;
            reject_pulse  <= 1'b0;
        end else begin
            confirm_pulse <= commit;
            reject_pulse  <= reject;
            if (state == COMMIT || do_clear || digit_count > max_digit) begin
                {key2, key1, key0} <= '0;
                digit_count        <= '0;
                state              <= IDLE;
            end else if (commit) state <= COMMIT;
            else if (do_shift) begin
                {key2, key1, key0} <= {key1, key0, key_code};
                digit_count        <= digit_count + 2'd1;
                state              <= (digit_count + 2'd1 == max_digit) ? READY : ENTRY;
            end else if (do_back) begin
                {key2, key1, key0} <= {4'h0, key2, key1};
                digit_count        <= digit_count - 2'd1;
                state              <= (digit_count == 2'd1) ? IDLE : ENTRY;
            end else state <= (digit_count == 2'd0) ? IDLE : (entry_ready ? READY : ENTRY);
        end
    end
endmodule

// File: tb/tb_guess_entry.sv
// tb_guess_entry: directed and random checks of guess_entry against a digit-queue model.
module tb_guess_entry;
    localparam int D = 4;
    logic clk = 0, restart = 0, key_valid = 0, confirm_n = 1;
    logic [3:0] key_code = 0;
    logic [1:0] max_digit = 2'd3;
    logic [3:0] key0, key1, key2;
    logic [1:0] digit_count;
    logic entry_ready, confirm_pulse, reject_pulse;
    int n_cmp = 0, n_err = 0;
    int guess[$];
    int lat;
    bit conf;

    always #5 clk = ~clk;

    guess_entry #(.DEBOUNCE_CYCLES(D), .CNT_W(5)) dut (
        .clk(clk), .restart(restart), .key_valid(key_valid), .key_code(key_code),
        .confirm_n(confirm_n), .max_digit(max_digit), .key0(key0), .key1(key1), .key2(key2),
        .digit_count(digit_count), .entry_ready(entry_ready),
        .confirm_pulse(confirm_pulse), .reject_pulse(reject_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_key(input int k);
        int v;
        v = (k < guess.size()) ? guess[guess.size() - 1 - k] : 0;
        return 4'(v);
    endfunction

    task automatic check_state();
        chk("key0", key0, exp_key(0));
        chk("key1", key1, exp_key(1));
        chk("key2", key2, exp_key(2));
        chk("digit_count", digit_count, guess.size());
        chk("entry_ready", entry_ready, max_digit != 0 && guess.size() == int'(max_digit));
    endtask

    task automatic model(input bit v, input logic [3:0] c);
        if (guess.size() > int'(max_digit)) guess.delete();
        else if (v && max_digit != 0) begin
            if (c <= 9 && guess.size() < int'(max_digit)) guess.push_back(int'(c));
            else if (c == 4'hA) guess.delete();
            else if (c == 4'hB && guess.size() > 0) void'(guess.pop_back());
        end
    endtask

    task automatic step(input bit v, input logic [3:0] c);
        key_valid = v;
        key_code = c;
        @(posedge clk);
        #1;
        key_valid = 0;
        model(v, c);
        check_state();
        chk("no_confirm", confirm_pulse, 0);
        chk("no_reject", reject_pulse, 0);
    endtask

    task automatic press(output int l, output bit cf);
        confirm_n = 0;
        l = 0;
        cf = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (confirm_pulse || reject_pulse) begin
                l = i;
                cf = confirm_pulse;
                break;
            end
        end
    endtask

    task automatic release_btn();
        confirm_n = 1;
        repeat (D + 4) step(0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_state();
        chk("rst_confirm", confirm_pulse, 0);
        chk("rst_reject", reject_pulse, 0);
        @(negedge clk);
        restart = 1;
        // full guess 4/7/2, extra digit ignored, then commit
        step(1, 4); step(1, 7); step(1, 2);
        chk("guess_key2", key2, 4);
        step(1, 9);
        press(lat, conf);
        chk("commit_latency", lat, 2 + D + 1);
        chk("commit_is_confirm", conf, 1);
        check_state();
        guess.delete();
        repeat (D + 4) step(0, 0);
        release_btn();
        // bouncing button on a ready guess does nothing
        step(1, 1); step(1, 2); step(1, 3);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) confirm_n = ~confirm_n;
            step(0, 0);
        end
        release_btn();
        step(1, 4'hA);
        // two-digit entry with backspace, clear, then reject
        max_digit = 2;
        step(1, 5); step(1, 4'hB); step(1, 8); step(1, 3);
        chk("bs_key1", key1, 8);
        chk("bs_key0", key0, 3);
        step(1, 4'hA);
        press(lat, conf);
        chk("reject_latency", lat, 2 + D + 1);
        chk("reject_not_confirm", conf, 0);
        step(0, 0);
        release_btn();
        // shrinking max_digit clears, max_digit 0 disables
        max_digit = 3;
        step(1, 1); step(1, 2); step(1, 3);
        max_digit = 1;
        step(0, 0);
        chk("shrink_count", digit_count, 0);
        max_digit = 0;
        step(1, 6);
        confirm_n = 0;
        repeat (D + 6) step(0, 0);
        release_btn();
        // reset during the commit cycle
        max_digit = 3;
        step(1, 4); step(1, 7); step(1, 2);
        press(lat, conf);
        chk("pre_reset_confirm", conf, 1);
        #2 restart = 0;
        #1;
        chk("async_drop", confirm_pulse, 0);
        chk("async_keys", key0, 0);
        guess.delete();
        confirm_n = 1;
        @(negedge clk);
        restart = 1;
        repeat (3) step(0, 0);
        max_digit = 1;
        step(1, 9);
        press(lat, conf);
        chk("post_reset_latency", lat, 2 + D + 1);
        chk("post_reset_confirm", conf, 1);
        guess.delete();
        step(0, 0);
        release_btn();
        // random key traffic with occasional max_digit changes
        for (int i = 0; i < 400; i++) begin
            if (i % 20 == 0) max_digit = 2'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
